// File: rtl/lsu_ld_arbiter.sv
// Round-robin arbiter sharing one DCache load port among LSU requesters.
// An in-order FIFO tracks owners of outstanding loads; flush kills entries.
module lsu_ld_arbiter #(
   parameter int NUM_REQ         = 2,
   parameter int PLEN            = 32,
   parameter int XLEN            = 32,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  flush_i,
   input  logic [NUM_REQ-1:0]    req_valid_i,
   output logic [NUM_REQ-1:0]    req_ready_o,
   input  logic [NUM_REQ*PLEN-1:0] req_addr_i,
   input  logic [NUM_REQ*4-1:0]  req_op_i,
   output logic [NUM_REQ-1:0]    rsp_valid_o,
   input  logic [NUM_REQ-1:0]    rsp_ready_i,
   output logic [XLEN-1:0]       rsp_data_o,
   output logic                  rsp_err_o,
   output logic                  dc_req_valid_o,
   input  logic                  dc_req_ready_i,
   output logic [PLEN-1:0]       dc_req_addr_o,
   output logic [3:0]            dc_req_op_o,
   input  logic                  dc_rsp_valid_i,
   output logic                  dc_rsp_ready_o,
   input  logic [XLEN-1:0]       dc_rsp_data_i,
   input  logic                  dc_rsp_err_i
);

   localparam int RW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(MAX_OUTSTANDING);

   logic [RW-1:0] rr_q, rr_d;
   logic [PW-1:0] head_q, head_d;
   logic [PW-1:0] tail_q, tail_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [RW-1:0] owner_q [MAX_OUTSTANDING];
   logic [RW-1:0] owner_d [MAX_OUTSTANDING];
   logic [MAX_OUTSTANDING-1:0] killed_q, killed_d;

   logic          gnt_found;
   logic [RW-1:0] gnt_idx;
   logic          full;
   logic          empty;
   logic          dc_hs;
   logic          push;
   logic          pop;
   logic [RW-1:0] head_owner;
   logic          head_killed;

   // (base + k) mod NUM_REQ, valid because base < NUM_REQ and k < NUM_REQ
   function automatic logic [RW-1:0] wrap_inc(input logic [RW-1:0] base,
                                              input int k);
      int s;
      s = int'(base) + k;
      if (s >= NUM_REQ) s = s - NUM_REQ;
      return s[RW-1:0];
   endfunction

   assign full        = (cnt_q == FULL_CNT);
   assign empty       = (cnt_q == '0);
   assign head_owner  = owner_q[head_q];
   assign head_killed = killed_q[head_q];

   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!gnt_found && req_valid_i[wrap_inc(rr_q, k)]) begin
            gnt_found = 1'b1;
            gnt_idx   = wrap_inc(rr_q, k);
         end
      end
   end

   always_comb begin
      dc_req_addr_o = '0;
      dc_req_op_o   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt_idx == RW'(i)) begin
            dc_req_addr_o = req_addr_i[i*PLEN +: PLEN];
            dc_req_op_o   = req_op_i[i*4 +: 4];
         end
      end
   end

   assign dc_req_valid_o = (|req_valid_i) && !full && !flush_i;
   assign dc_hs          = dc_req_valid_o && dc_req_ready_i;
   assign push           = dc_hs && !rst_i;

   always_comb begin
      req_ready_o = '0;
      if (push) req_ready_o[gnt_idx] = 1'b1;
   end

   // Killed heads are drained without notifying any requester
   always_comb begin
      rsp_valid_o    = '0;
      dc_rsp_ready_o = 1'b0;
      if (!rst_i && !empty) begin
         if (head_killed) begin
            dc_rsp_ready_o = 1'b1;
         end else begin
            rsp_valid_o[head_owner] = dc_rsp_valid_i;
            dc_rsp_ready_o          = rsp_ready_i[head_owner];
         end
      end
   end

   assign rsp_data_o = dc_rsp_data_i;
   assign rsp_err_o  = dc_rsp_err_i;
   assign pop        = dc_rsp_valid_i && dc_rsp_ready_o;

   always_comb begin
      rr_d     = rr_q;
      head_d   = head_q + PW'(pop);
      tail_d   = tail_q + PW'(push);
      cnt_d    = cnt_q + CW'(push) - CW'(pop);
      owner_d  = owner_q;
      killed_d = killed_q;
      if (flush_i) killed_d = '1;
      if (push) begin
         rr_d             = wrap_inc(gnt_idx, 1);
         owner_d[tail_q]  = gnt_idx;
         killed_d[tail_q] = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rr_q     <= '0;
         head_q   <= '0;
         tail_q   <= '0;
         cnt_q    <= '0;
         owner_q  <= '{default: '0};
         killed_q <= '0;
      end else begin
         rr_q     <= rr_d;
         head_q   <= head_d;
         tail_q   <= tail_d;
         cnt_q    <= cnt_d;
         owner_q  <= owner_d;
         killed_q <= killed_d;
      end
   end

endmodule
